// File: rtl/ctrl_pipe.sv
// Control and hazard logic for the 5-stage MIPS pipeline. It carries the decode control bundle
// through ID/EX, EX/MEM and MEM/WB, and generates the stall, flush and forwarding controls.
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             d_clk,
  input  logic             d_rst_n,
  input  logic             id_regdst,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  output logic             ex_regdst,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             mem_regwrite,
  output logic [REG_W-1:0] mem_wreg,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [REG_W-1:0] wb_wreg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic [REG_W-1:0] exRd;
  logic [REG_W-1:0] exWreg;
  logic             stall;
  logic             bubble;

  assign exWreg = ex_regdst ? exRd : ex_rt;

  assign stall  = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign bubble = stall || ex_branch_taken;

  // A taken branch overrides the stall: the held instruction is squashed anyway.
  assign pc_write   = !stall || ex_branch_taken;
  assign ifid_write = !stall || ex_branch_taken;
  assign ifid_flush = ex_branch_taken;

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      exRd        <= '0;
    end else if (bubble) begin
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      exRd        <= '0;
    end else begin
      ex_regdst   <= id_regdst;
      ex_branch   <= id_branch;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_regwrite;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      exRd        <= id_rd;
    end
  end

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_wreg     <= '0;
      wb_memtoreg  <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_wreg      <= '0;
    end else begin
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_regwrite <= ex_regwrite;
      mem_wreg     <= exWreg;
      wb_memtoreg  <= mem_memtoreg;
      wb_regwrite  <= mem_regwrite;
      wb_wreg      <= mem_wreg;
    end
  end

  // The nearer producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rs))
      fwd_a = 2'b10;
    else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rs))
      fwd_a = 2'b01;
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rt))
      fwd_b = 2'b10;
    else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rt))
      fwd_b = 2'b01;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe. Each instruction is tracked through a three-slot pipeline model,
// and every DUT output is checked on every cycle, for directed cases and random traffic.
module tb_ctrl_pipe;
  localparam int REG_W = 5;

  typedef struct packed {
    logic             regdst, branch, memread, memwrite, memtoreg, alusrc, regwrite;
    logic [REG_W-1:0] rs, rt, rd;
  } instr_t;

  logic d_clk = 1'b0;
  logic d_rst_n;
  logic id_regdst, id_branch, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regwrite;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic ex_branch_taken;
  logic ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite;
  logic [REG_W-1:0] ex_rs, ex_rt;
  logic mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [REG_W-1:0] mem_wreg;
  logic wb_memtoreg, wb_regwrite;
  logic [REG_W-1:0] wb_wreg;
  logic pc_write, ifid_write, ifid_flush;
  logic [1:0] fwd_a, fwd_b;

  always #5 d_clk = ~d_clk;

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .d_clk(d_clk), .d_rst_n(d_rst_n),
    .id_regdst(id_regdst), .id_branch(id_branch), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // pipe[0] = instruction in EX, pipe[1] = in MEM, pipe[2] = in WB
  instr_t pipe [3];
  instr_t cur;
  logic   curBt;
  int     nCmp = 0;
  int     nFail = 0;

  function automatic logic [REG_W-1:0] destOf(instr_t i);
    return i.regdst ? i.rd : i.rt;
  endfunction

  function automatic logic stallExp(instr_t id);
    return pipe[0].memread && (pipe[0].rt != 0) && ((pipe[0].rt == id.rs) || (pipe[0].rt == id.rt));
  endfunction

  function automatic logic [1:0] fwdExp(logic [REG_W-1:0] src);
    if (src == 0) return 2'b00;
    if (pipe[1].regwrite && destOf(pipe[1]) == src) return 2'b10;
    if (pipe[2].regwrite && destOf(pipe[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t rtype(int rs, int rt, int rd);
    instr_t i = '0;
    i.regdst = 1'b1; i.regwrite = 1'b1;
    i.rs = REG_W'(rs); i.rt = REG_W'(rt); i.rd = REG_W'(rd);
    return i;
  endfunction

  function automatic instr_t load(int rs, int rt);
    instr_t i = '0;
    i.memread = 1'b1; i.memtoreg = 1'b1; i.alusrc = 1'b1; i.regwrite = 1'b1;
    i.rs = REG_W'(rs); i.rt = REG_W'(rt);
    return i;
  endfunction

  function automatic instr_t store(int rs, int rt);
    instr_t i = '0;
    i.memwrite = 1'b1; i.alusrc = 1'b1;
    i.rs = REG_W'(rs); i.rt = REG_W'(rt);
    return i;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic st;
    st = stallExp(cur);
    cmp("exStage",
        {ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite, ex_rs, ex_rt},
        {pipe[0].regdst, pipe[0].branch, pipe[0].memread, pipe[0].memwrite, pipe[0].memtoreg,
         pipe[0].alusrc, pipe[0].regwrite, pipe[0].rs, pipe[0].rt});
    cmp("memStage", {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_wreg},
        {pipe[1].memread, pipe[1].memwrite, pipe[1].memtoreg, pipe[1].regwrite, destOf(pipe[1])});
    cmp("wbStage", {wb_memtoreg, wb_regwrite, wb_wreg},
        {pipe[2].memtoreg, pipe[2].regwrite, destOf(pipe[2])});
    cmp("hazard", {pc_write, ifid_write, ifid_flush}, {!st || curBt, !st || curBt, curBt});
    cmp("fwd", {fwd_a, fwd_b}, {fwdExp(pipe[0].rs), fwdExp(pipe[0].rt)});
  endtask

  task automatic drive(input instr_t i, input logic bt);
    cur = i; curBt = bt;
    id_regdst = i.regdst; id_branch = i.branch; id_memread = i.memread;
    id_memwrite = i.memwrite; id_memtoreg = i.memtoreg; id_alusrc = i.alusrc;
    id_regwrite = i.regwrite; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    ex_branch_taken = bt;
  endtask

  // Called at posedge+1: apply inputs, check mid-cycle, then take the edge.
  task automatic stepPre(input instr_t i, input logic bt);
    drive(i, bt);
    #3;
    checkAll();
  endtask

  task automatic stepPost();
    logic bub;
    bub = stallExp(cur) || curBt;
    @(posedge d_clk);
    if (d_rst_n) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = bub ? '0 : cur;
    end
    #1;
  endtask

  task automatic step(input instr_t i, input logic bt);
    stepPre(i, bt);
    stepPost();
  endtask

  task automatic midReset();
    d_rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    checkAll();
    cmp("resetPcWrite", {pc_write, fwd_a, fwd_b}, {1'b1, 4'b0000});
    @(posedge d_clk);
    #1;
    d_rst_n = 1'b1;
    checkAll();
  endtask

  initial begin
    instr_t r;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    drive(nop(), 1'b0);
    d_rst_n = 1'b0;
    #2;
    checkAll();
    cmp("resetOutputs", {pc_write, ifid_write, ifid_flush, fwd_a, fwd_b}, {3'b110, 4'b0000});
    @(posedge d_clk);
    #1;
    d_rst_n = 1'b1;

    // R-type propagation
    step(rtype(1, 7, 5), 1'b0);
    step(nop(), 1'b0);
    cmp("rtypeMemWreg", {mem_regwrite, mem_wreg}, {1'b1, 5'd5});
    step(nop(), 1'b0);
    cmp("rtypeWb", {wb_regwrite, wb_wreg}, {1'b1, 5'd5});

    // Load-use: one stall cycle, bubble in EX, dependent enters one edge later
    step(load(2, 8), 1'b0);
    stepPre(rtype(8, 3, 9), 1'b0);
    cmp("loadUseStall", {pc_write, ifid_write}, 2'b00);
    stepPost();
    cmp("loadUseBubble", {ex_memread, ex_regwrite, ex_regdst, ex_rs, ex_rt}, '0);
    stepPre(rtype(8, 3, 9), 1'b0);
    cmp("loadUseResume", {pc_write, ifid_write}, 2'b11);
    stepPost();
    cmp("depInEx", {ex_regwrite, ex_rs}, {1'b1, 5'd8});

    // Forward priority
    step(rtype(1, 2, 3), 1'b0);
    step(rtype(1, 2, 3), 1'b0);
    step(rtype(3, 0, 4), 1'b0);
    cmp("fwdBoth", fwd_a, 2'b10);
    step(rtype(1, 2, 3), 1'b0);
    step(store(1, 2), 1'b0);
    step(rtype(3, 0, 4), 1'b0);
    cmp("fwdWbOnly", fwd_a, 2'b01);
    step(rtype(1, 2, 0), 1'b0);
    step(rtype(1, 2, 0), 1'b0);
    step(rtype(0, 0, 4), 1'b0);
    cmp("fwdReg0", {fwd_a, fwd_b}, 4'b0000);

    // Branch flush while the stall condition holds
    step(load(2, 8), 1'b0);
    stepPre(rtype(8, 1, 2), 1'b1);
    cmp("flushOverStall", {pc_write, ifid_write, ifid_flush}, 3'b111);
    stepPost();
    cmp("flushBubble", {ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
                        ex_alusrc, ex_regwrite, ex_rs, ex_rt}, '0);
    cmp("branchAdvances", {mem_memread, mem_regwrite, mem_wreg}, {2'b11, 5'd8});

    // Store
    step(store(1, 2), 1'b0);
    cmp("storeEx", {ex_alusrc, ex_memwrite}, 2'b11);
    step(nop(), 1'b0);
    cmp("storeMem", {mem_memwrite, mem_regwrite}, 2'b10);
    step(nop(), 1'b0);
    cmp("storeWb", wb_regwrite, 1'b0);

    // Random traffic on a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      r = instr_t'({$urandom, $urandom});
      r.rs = REG_W'($urandom_range(0, 3));
      r.rt = REG_W'($urandom_range(0, 3));
      r.rd = REG_W'($urandom_range(0, 3));
      if (n == 150 || n == 300) midReset();
      else step(r, ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
